alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU between two requesters: port 0 is the main datapath, port 1 is the address/branch helper unit.
- Each requester issues {operand A, operand B, 4-bit ALU control} over a valid/ready handshake.
- The arbiter grants one request at a time using round-robin, drives the ALU from registered operands, and returns the captured result and zero flag to the winner.
- Sits between the requesters and the ALU instance inside the top-level datapath.

Parameters:
- WIDTH, 32, operand/result width (standard MIPS word).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- CLK  input  1  clock.
- RESET  input  1  synchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has a request.
- REQ0_READY  output  1  request 0 accepted this cycle.
- REQ0_A, REQ0_B  input  WIDTH  requester 0 operands.
- REQ0_CTRL  input  4  requester 0 ALU control code.
- RSP0_VALID  output  1  response for requester 0 available.
- RSP0_READY  input  1  requester 0 consumes the response.
- RSP0_RESULT  output  WIDTH  result returned to requester 0.
- RSP0_ZERO  output  1  zero flag returned to requester 0.
- RSP0_ERR  output  1  requester 0 issued an illegal control code.
- REQ1_*, RSP1_*  same set as port 0, for requester 1.
- ALU_IN_1, ALU_IN_2  output  WIDTH  operands to the ALU.
- ALU_control  output  4  ALU operation select.
- ALU_result  input  WIDTH  ALU result.
- ALU_zero  input  1  ALU zero flag.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. All state updates occur on the rising edge of CLK.
- Reset values:
  - State is IDLE; round-robin pointer points to port 0.
  - All READY, RSP_VALID and RSP_ERR outputs are 0.
  - RSP_RESULT, RSP_ZERO, ALU_IN_1, ALU_IN_2 are 0; ALU_control is 4'b0010.
- IDLE:
  - Arbitration is combinational over REQx_VALID.
  - If only one port is valid, it wins.
  - If both are valid, the port the pointer points to wins.
  - REQx_READY=1 for the winner only, during this IDLE cycle only.
  - On acceptance: latch A, B, CTRL and the winner id; move the pointer to the other port; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (1 cycle):
  - ALU_IN_1, ALU_IN_2 and ALU_control are driven from the latched values.
  - At the end of the cycle, capture ALU_result and ALU_zero into the winner's response registers; go to RESP.
- Illegal control codes:
  - Legal codes are 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - Any other code skips the ALU capture and returns RESULT=0, ZERO=0, ERR=1.
  - The response still goes through EXEC and RESP with unchanged timing.
- RESP:
  - RSPx_VALID=1 for the winner; RESULT, ZERO and ERR are held stable.
  - On RSPx_READY=1: clear VALID and go to IDLE.
  - A new request cannot be accepted in the same cycle.
- Latency:
  - Acceptance in cycle N gives RSP_VALID in cycle N+2.
  - Minimum request-to-request spacing is 3 cycles.
- ALU drive outside EXEC: ALU signals keep their last driven values (no toggling).
- The losing requester's VALID is ignored until the next IDLE. Requesters must hold VALID and operands stable until READY.
- RSP_READY asserted when RSP_VALID=0 is ignored.
- RESET in any state aborts the operation: outstanding responses are dropped and all reset values are restored in the next cycle.
- The non-winning port's RSP outputs keep their previous RESULT/ZERO/ERR values, with VALID=0.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs GRANT0_CNT and GRANT1_CNT (CNT_W bits each) and ERR_CNT (CNT_W bits).
  - GRANTx_CNT increments on each REQx acceptance; ERR_CNT increments on each illegal-code request.
  - All counters saturate at all-ones and clear on RESET.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - The state encoding (IDLE, EXEC, RESP).
  - An alu_ctrl_legal function.
- One sub-module, rr_arbiter2: a 2-way round-robin arbiter with pointer register, covering grant logic and pointer update.

Test Plan:
- Single request: REQ0 A=5, B=3, CTRL=0010 -> READY0 in the accept cycle; two cycles later RSP0_RESULT=8, RSP0_ZERO=0, RSP0_ERR=0.
- Contention: both ports valid at the same time after reset -> port 0 granted first, port 1 next; with both held valid, grants alternate 0,1,0,1.
- Zero flag: REQ1 A=7, B=7, CTRL=0110 -> RSP1_RESULT=0, RSP1_ZERO=1.
- Illegal code: REQ0 CTRL=0011 -> RSP0_ERR=1, RESULT=0, ZERO=0; response at N+2 and the ALU result is not captured.
- Backpressure: hold RSP1_READY=0 for 5 cycles -> RSP1_VALID and RESULT stay stable; REQ0 is not accepted until one cycle after RSP1_READY.
- Reset mid-EXEC: assert RESET -> the next cycle shows all outputs at reset values and the pointer at port 0; with ALU_ARB_STATS_EN defined, the counters are 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, arbiter state encoding and the control-code legality check.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: alu_ctrl_legal = 1'b1;
            default:                                             alu_ctrl_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the port the pointer names.
// Latency: grant is combinational; the pointer moves to the loser's side on the granting edge.
// Backpressure: no grant while en is low, and the pointer holds its value.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Winner 0 hands priority to port 1 and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between two requesters; ALU_ARB_STATS_EN adds grant/error counters.
// Latency: accept in cycle N, response valid in N+2; next acceptance no earlier than N+3.
// Backpressure: one operation in flight; a held response blocks all new requests until consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    input  logic [3:0]       REQ0_CTRL,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic [WIDTH-1:0] RSP0_RESULT,
    output logic             RSP0_ZERO,
    output logic             RSP0_ERR,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    input  logic [3:0]       REQ1_CTRL,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [WIDTH-1:0] RSP1_RESULT,
    output logic             RSP1_ZERO,
    output logic             RSP1_ERR,
    output logic [WIDTH-1:0] ALU_IN_1,
    output logic [WIDTH-1:0] ALU_IN_2,
    output logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] ALU_result,
    input  logic             ALU_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] GRANT0_CNT,
    output logic [CNT_W-1:0] GRANT1_CNT,
    output logic [CNT_W-1:0] ERR_CNT
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
    } req_t;

    arb_state_t       state, state_nxt;
    req_t             req0_dat, req1_dat, acc_dat, req_q;
    logic             win_q;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             accept, capture, rsp_take;
    logic             op_legal;
    logic [1:0]       rsp_vld, rsp_zero, rsp_err;
    logic [WIDTH-1:0] rsp_res [2];

    assign req0_dat = '{a: REQ0_A, b: REQ0_B, ctrl: REQ0_CTRL};
    assign req1_dat = '{a: REQ1_A, b: REQ1_B, ctrl: REQ1_CTRL};
    assign acc_dat  = gnt[1] ? req1_dat : req0_dat;
    assign op_legal = alu_ctrl_legal(req_q.ctrl);

    // Arbitration only while idle and out of reset, so READY never pulses during a reset cycle.
    assign arb_en = (state == IDLE) && !RESET;

    rr_arbiter2 u_rr (
        .clk   (CLK),
        .reset (RESET),
        .en    (arb_en),
        .req   ({REQ1_VALID, REQ0_VALID}),
        .gnt   (gnt)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (win_q ? RSP1_READY : RSP0_READY) begin
                    rsp_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The latched request drives the ALU directly, so it stays still between operations.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_q      <= '{a: '0, b: '0, ctrl: ALU_ADD};
            win_q      <= 1'b0;
            rsp_vld    <= 2'b00;
            rsp_zero   <= 2'b00;
            rsp_err    <= 2'b00;
            rsp_res[0] <= '0;
            rsp_res[1] <= '0;
        end else begin
            if (accept) begin
                req_q <= acc_dat;
                win_q <= gnt[1];
            end
            if (capture) begin
                rsp_vld[win_q]  <= 1'b1;
                rsp_err[win_q]  <= !op_legal;
                rsp_res[win_q]  <= op_legal ? ALU_result : '0;
                rsp_zero[win_q] <= op_legal && ALU_zero;
            end
            if (rsp_take) begin
                rsp_vld[win_q] <= 1'b0;
            end
        end
    end

    assign REQ0_READY  = gnt[0];
    assign REQ1_READY  = gnt[1];
    assign RSP0_VALID  = rsp_vld[0];
    assign RSP0_RESULT = rsp_res[0];
    assign RSP0_ZERO   = rsp_zero[0];
    assign RSP0_ERR    = rsp_err[0];
    assign RSP1_VALID  = rsp_vld[1];
    assign RSP1_RESULT = rsp_res[1];
    assign RSP1_ZERO   = rsp_zero[1];
    assign RSP1_ERR    = rsp_err[1];
    assign ALU_IN_1    = req_q.a;
    assign ALU_IN_2    = req_q.b;
    assign ALU_control = req_q.ctrl;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt [2];
    logic [CNT_W-1:0] err_cnt;

    // Saturating counters; illegal codes are counted when the request is accepted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant_cnt[0] <= '0;
            grant_cnt[1] <= '0;
            err_cnt      <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
                end
            end
            if (accept && !alu_ctrl_legal(acc_dat.ctrl) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign GRANT0_CNT = grant_cnt[0];
    assign GRANT1_CNT = grant_cnt[1];
    assign ERR_CNT    = err_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, reset-in-EXEC sequence, random rounds vs a transaction model.
module tb_alu_share_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0_VALID, REQ0_READY, RSP0_VALID, RSP0_READY, RSP0_ZERO, RSP0_ERR;
    logic        REQ1_VALID, REQ1_READY, RSP1_VALID, RSP1_READY, RSP1_ZERO, RSP1_ERR;
    logic [31:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B, RSP0_RESULT, RSP1_RESULT;
    logic [3:0]  REQ0_CTRL, REQ1_CTRL, ALU_control;
    logic [31:0] ALU_IN_1, ALU_IN_2, ALU_result;
    logic        ALU_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  c0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  c1;
        int          win;
        logic [31:0] res;
        logic        z, e;
        int          bp;
    } vec_t;

    vec_t        vecs[10];
    int          prefer;
    logic [31:0] last_res[2];
    logic        last_z[2], last_e[2];

    alu_share_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ0_CTRL(REQ0_CTRL), .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
        .RSP0_RESULT(RSP0_RESULT), .RSP0_ZERO(RSP0_ZERO), .RSP0_ERR(RSP0_ERR),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ1_CTRL(REQ1_CTRL), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
        .RSP1_RESULT(RSP1_RESULT), .RSP1_ZERO(RSP1_ZERO), .RSP1_ERR(RSP1_ERR),
        .ALU_IN_1(ALU_IN_1), .ALU_IN_2(ALU_IN_2), .ALU_control(ALU_control),
        .ALU_result(ALU_result), .ALU_zero(ALU_zero)
    );

    always #5 CLK = ~CLK;

    // MIPS ALU semantics; ok=0 marks a code outside the legal set.
    function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ok);
        ok = 1'b1;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: begin r = 32'd0; ok = 1'b0; end
        endcase
    endfunction

    // Behavioural ALU; an illegal code yields a poison value that must never reach a response.
    logic [31:0] alu_r;
    logic        alu_ok;
    always_comb ref_alu(ALU_control, ALU_IN_1, ALU_IN_2, alu_r, alu_ok);
    assign ALU_result = alu_ok ? alu_r : 32'hDEAD_BEEF;
    assign ALU_zero   = alu_ok ? (alu_r == 32'd0) : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_ready0", REQ0_READY, 0);
        check("rst_ready1", REQ1_READY, 0);
        check("rst_rsp0_valid", RSP0_VALID, 0);
        check("rst_rsp1_valid", RSP1_VALID, 0);
        check("rst_rsp0_result", RSP0_RESULT, 0);
        check("rst_rsp1_result", RSP1_RESULT, 0);
        check("rst_zero_err", {RSP0_ZERO, RSP0_ERR, RSP1_ZERO, RSP1_ERR}, 0);
        check("rst_alu_in1", ALU_IN_1, 0);
        check("rst_alu_in2", ALU_IN_2, 0);
        check("rst_alu_ctrl", ALU_control, 4'b0010);
    endtask

    // Entered #1 after an edge with the DUT idle; returns #1 after the edge that consumes the response.
    task automatic run_round(input vec_t v);
        int w = v.win;
        int o = 1 - v.win;
        REQ0_VALID = v.v0; REQ0_A = v.a0; REQ0_B = v.b0; REQ0_CTRL = v.c0;
        REQ1_VALID = v.v1; REQ1_A = v.a1; REQ1_B = v.b1; REQ1_CTRL = v.c1;
        // The idle port keeps READY high to show it is ignored without a response.
        RSP0_READY = (o == 0); RSP1_READY = (o == 1);
        @(negedge CLK);
        check("accept_ready0", REQ0_READY, w == 0);
        check("accept_ready1", REQ1_READY, w == 1);
        @(posedge CLK); #1;
        if (w == 0) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
        @(negedge CLK);
        check("exec_rsp_valid", {RSP1_VALID, RSP0_VALID}, 0);
        check("exec_alu_in1", ALU_IN_1, (w == 0) ? v.a0 : v.a1);
        check("exec_alu_in2", ALU_IN_2, (w == 0) ? v.b0 : v.b1);
        check("exec_alu_ctrl", ALU_control, (w == 0) ? v.c0 : v.c1);
        @(posedge CLK); #1;
        for (int k = 0; k <= v.bp; k++) begin
            if (k == v.bp) begin
                if (w == 0) RSP0_READY = 1'b1; else RSP1_READY = 1'b1;
            end
            @(negedge CLK);
            check("resp_win_valid", (w == 0) ? RSP0_VALID : RSP1_VALID, 1);
            check("resp_win_result", (w == 0) ? RSP0_RESULT : RSP1_RESULT, v.res);
            check("resp_win_zero", (w == 0) ? RSP0_ZERO : RSP1_ZERO, v.z);
            check("resp_win_err", (w == 0) ? RSP0_ERR : RSP1_ERR, v.e);
            check("resp_other_valid", (o == 0) ? RSP0_VALID : RSP1_VALID, 0);
            check("resp_other_result", (o == 0) ? RSP0_RESULT : RSP1_RESULT, last_res[o]);
            check("resp_other_flags", (o == 0) ? {RSP0_ZERO, RSP0_ERR} : {RSP1_ZERO, RSP1_ERR},
                  {last_z[o], last_e[o]});
            check("resp_no_accept", {REQ1_READY, REQ0_READY}, 0);
            check("resp_alu_hold", ALU_IN_1, (w == 0) ? v.a0 : v.a1);
            @(posedge CLK); #1;
        end
        RSP0_READY = 1'b0; RSP1_READY = 1'b0;
        last_res[w] = v.res; last_z[w] = v.z; last_e[w] = v.e;
        prefer = 1 - w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  codes[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        logic        pend[2];
        logic [31:0] pa[2], pb[2];
        logic [3:0]  pc[2];
        vec_t        rv;

        vecs[0] = '{1'b1, 32'd5, 32'd3, 4'b0010, 1'b1, 32'd7, 32'd7, 4'b0110, 0, 32'd8, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 32'hF0, 32'h0F, 4'b0001, 1'b1, 32'd7, 32'd7, 4'b0110, 1, 32'd0, 1'b1, 1'b0, 5};
        vecs[2] = '{1'b1, 32'hF0, 32'h0F, 4'b0001, 1'b1, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000,
                    0, 32'hFF, 1'b0, 1'b0, 1};
        vecs[3] = '{1'b1, 32'd9, 32'd4, 4'b0011, 1'b1, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000,
                    1, 32'h0F000F00, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b1, 32'd9, 32'd4, 4'b0011, 1'b0, 32'd0, 32'd0, 4'b0000, 0, 32'd0, 1'b0, 1'b1, 2};
        vecs[5] = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0111, 1, 32'd1, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b1, 32'd0, 32'd0, 4'b1100, 1'b0, 32'd0, 32'd0, 4'b0000, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd3, 32'd5, 4'b0110, 1, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
        vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 4'b0000, 0, 32'd0, 1'b1, 1'b0, 0};
        vecs[9] = '{1'b1, 32'd5, 32'd3, 4'b0010, 1'b0, 32'd0, 32'd0, 4'b0000, 0, 32'd8, 1'b0, 1'b0, 0};

        RESET = 1'b1;
        REQ0_VALID = 0; REQ0_A = 0; REQ0_B = 0; REQ0_CTRL = 0; RSP0_READY = 0;
        REQ1_VALID = 0; REQ1_A = 0; REQ1_B = 0; REQ1_CTRL = 0; RSP1_READY = 0;
        for (int p = 0; p < 2; p++) begin
            last_res[p] = 0; last_z[p] = 0; last_e[p] = 0; pend[p] = 0;
        end
        prefer = 0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_reset_state();
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) run_round(vecs[i]);

        // Random rounds: a pending request stays valid with fixed operands until it wins.
        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
                    pend[p] = 1'b1;
                    pa[p] = $urandom;
                    pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
                    pc[p] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1; pa[0] = $urandom; pb[0] = $urandom; pc[0] = 4'b0010;
            end
            rv.v0 = pend[0]; rv.a0 = pa[0]; rv.b0 = pb[0]; rv.c0 = pc[0];
            rv.v1 = pend[1]; rv.a1 = pa[1]; rv.b1 = pb[1]; rv.c1 = pc[1];
            rv.win = (pend[0] && pend[1]) ? prefer : (pend[0] ? 0 : 1);
            begin
                logic [31:0] r;
                logic        ok;
                ref_alu(pc[rv.win], pa[rv.win], pb[rv.win], r, ok);
                rv.res = ok ? r : 32'd0;
                rv.z   = ok && (r == 32'd0);
                rv.e   = !ok;
            end
            rv.bp = $urandom_range(0, 3);
            run_round(rv);
            pend[rv.win] = 1'b0;
        end
        REQ0_VALID = 0; REQ1_VALID = 0;

        // Reset while a SUB is executing: pointer had moved to port 1 and must return to port 0.
        REQ0_VALID = 1; REQ0_A = 32'd5; REQ0_B = 32'd3; REQ0_CTRL = 4'b0110;
        @(negedge CLK);
        check("pre_reset_ready0", REQ0_READY, 1);
        @(posedge CLK); #1;
        REQ0_VALID = 0; RESET = 1'b1;
        @(negedge CLK);
        check("pre_reset_exec_in1", ALU_IN_1, 32'd5);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_state();
        @(posedge CLK); #1;
        for (int p = 0; p < 2; p++) begin last_res[p] = 0; last_z[p] = 0; last_e[p] = 0; end
        prefer = 0;
        rv = '{1'b1, 32'd1, 32'd2, 4'b0010, 1'b1, 32'd4, 32'd1, 4'b0001, 0, 32'd3, 1'b0, 1'b0, 0};
        run_round(rv);
        rv = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd4, 32'd1, 4'b0001, 1, 32'd5, 1'b0, 1'b0, 0};
        run_round(rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
